interrupt_arbiter: RTL and testbench
====================================

INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports named CLK and RESET.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 Interrupt_Register  input  16  pending-interrupt bits from the interrupt capture register; bit n = source n.
REQ-005 MASK_WRITE  input  1  load enable for the mask register.
REQ-006 MASK_DATA  input  16  new mask value; 1 = source enabled.
REQ-007 INT_ACK  input  1  control FSM strobe: EPC saved, vector taken.
REQ-008 RETI  input  1  control FSM strobe: return-from-interrupt executed.
REQ-009 IRQ  output  1  interrupt request to the control FSM.
REQ-010 VECTOR  output  16  handler address for the granted source.
REQ-011 IR_CLR_SELECT  output  4  index of the pending bit to clear.
REQ-012 IR_CLR  output  1  one-cycle clear strobe qualifying IR_CLR_SELECT.
REQ-013 IN_SERVICE  output  1  a handler is running.
REQ-014 ACTIVE_ID  output  4  index of the granted or in-service source.
REQ-015 INT_COUNT  output  8  count of acknowledged interrupts.
REQ-016 MASK  output  16  current mask register.
REQ-017 arb_state  output  2  FSM state encoding: IDLE=0, REQ=1, CLEAR=2, SERVICE=3.

Function
REQ-018 Eligible set = Interrupt_Register AND MASK; the lowest set index SHALL have the highest priority.
REQ-019 MASK SHALL load MASK_DATA on the edge where MASK_WRITE=1, in any state; arbitration in that same cycle uses the old MASK.
REQ-020 In IDLE, a nonzero eligible set SHALL cause a transition to REQ at the next edge, and the winning index SHALL be latched into ACTIVE_ID on that edge.
REQ-021 In REQ, IRQ SHALL be 1 and ACTIVE_ID SHALL be frozen; higher-priority arrivals and mask changes do not re-arbitrate.
REQ-022 REQ with INT_ACK=1 SHALL go to CLEAR, and INT_COUNT SHALL increment, saturating at 255.
REQ-023 CLEAR SHALL last exactly one cycle with IR_CLR=1, then go to SERVICE.
REQ-024 IR_CLR_SELECT SHALL equal ACTIVE_ID at all times; IR_CLR SHALL be 0 outside CLEAR.
REQ-025 In SERVICE, IN_SERVICE SHALL be 1; RETI=1 SHALL return the FSM to IDLE at the next edge.
REQ-026 There is no nesting: pending sources wait in SERVICE.
REQ-027 VECTOR SHALL be 16'h0F00 + (ACTIVE_ID x 16), combinational from ACTIVE_ID.
REQ-028 INT_ACK outside REQ and RETI outside SERVICE SHALL be ignored.
REQ-029 The latency from an eligible bit in IDLE to IRQ=1 SHALL be exactly 1 cycle.
REQ-030 A pending bit that drops while in REQ SHALL NOT withdraw IRQ; the grant completes.
REQ-031 IRQ, IR_CLR and IN_SERVICE SHALL be registered-state decodes with no glitch paths from inputs.

Reset
REQ-032 RESET=1 SHALL immediately force: arb_state=IDLE, MASK=16'h0000, ACTIVE_ID=0, INT_COUNT=0.
REQ-033 During reset, IRQ=0, IR_CLR=0, IN_SERVICE=0, IR_CLR_SELECT=0 and VECTOR=16'h0F00.
REQ-034 Reset asserted mid-REQ, mid-CLEAR or mid-SERVICE SHALL abandon the grant without issuing IR_CLR.
REQ-035 The FSM SHALL resume arbitration at the first rising edge after reset deasserts.

Verification
REQ-036 Scenario: MASK=16'hFFFF, Interrupt_Register=16'h0028 -> next cycle IRQ=1, ACTIVE_ID=3, VECTOR=16'h0F30.
REQ-037 Scenario: INT_ACK pulsed in REQ -> one cycle IR_CLR=1 with IR_CLR_SELECT=3, then IN_SERVICE=1, INT_COUNT=1.
REQ-038 Scenario: in SERVICE, Interrupt_Register=16'h0001 -> IRQ stays 0; after RETI, IRQ=1 one cycle later with ACTIVE_ID=0.
REQ-039 Scenario: MASK=16'h0000, Interrupt_Register=16'hFFFF -> IRQ remains 0; then MASK_WRITE with 16'h8000 -> next cycle IRQ=1, ACTIVE_ID=15, VECTOR=16'h0FF0.
REQ-040 Scenario: 260 ack/RETI cycles -> INT_COUNT holds at 255.
REQ-041 Scenario: RESET asserted while in SERVICE -> IN_SERVICE=0 and MASK=0 immediately, no IR_CLR pulse.

Source files
------------

// File: rtl/interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_arbiter
// Purpose  : Fixed-priority interrupt arbiter with mask register, a four-state
//            grant/clear/service handshake toward the control FSM, a vector
//            generator and a saturating count of acknowledged interrupts.
//            Source 0 has the highest priority.
// Ports    : CLK, RESET (async, active-high)
//            Interrupt_Register[15:0] - pending bits, bit n = source n
//            MASK_WRITE, MASK_DATA     - mask register load (1 = enabled)
//            INT_ACK, RETI             - strobes from the control FSM
//            IRQ, VECTOR, IR_CLR_SELECT, IR_CLR, IN_SERVICE, ACTIVE_ID,
//            INT_COUNT, MASK, arb_state (IDLE=0 REQ=1 CLEAR=2 SERVICE=3)
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_arbiter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] Interrupt_Register,
  input  logic        MASK_WRITE,
  input  logic [15:0] MASK_DATA,
  input  logic        INT_ACK,
  input  logic        RETI,
  output logic        IRQ,
  output logic [15:0] VECTOR,
  output logic [3:0]  IR_CLR_SELECT,
  output logic        IR_CLR,
  output logic        IN_SERVICE,
  output logic [3:0]  ACTIVE_ID,
  output logic [7:0]  INT_COUNT,
  output logic [15:0] MASK,
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_CLEAR   = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  localparam logic [15:0] c_VECTOR_BASE = 16'h0F00;

  state_t      r_state;
  logic [15:0] r_mask;
  logic [3:0]  r_active_id;
  logic [7:0]  r_count;

  logic [15:0] w_elig;
  logic        w_any;
  logic [3:0]  w_win;

  // Eligibility uses the mask register's current value, so a mask write
  // takes effect for arbitration only from the following cycle.
  assign w_elig = Interrupt_Register & r_mask;
  assign w_any  = |w_elig;

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    w_win = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win = i[3:0];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_mask      <= 16'h0000;
      r_active_id <= 4'd0;
      r_count     <= 8'd0;
    end else begin
      if (MASK_WRITE) begin
        r_mask <= MASK_DATA;
      end
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_REQ;
            r_active_id <= w_win;
          end
        end
        // The grant is frozen here: no re-arbitration, and a pending bit
        // that drops does not withdraw the request.
        S_REQ: begin
          if (INT_ACK) begin
            r_state <= S_CLEAR;
            if (r_count != 8'hFF) begin
              r_count <= r_count + 8'd1;
            end
          end
        end
        S_CLEAR: begin
          r_state <= S_SERVICE;
        end
        S_SERVICE: begin
          if (RETI) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status strobes decode only the state register, so they cannot glitch
  // on input changes.
  assign IRQ           = (r_state == S_REQ);
  assign IR_CLR        = (r_state == S_CLEAR);
  assign IN_SERVICE    = (r_state == S_SERVICE);
  assign arb_state     = r_state;
  assign ACTIVE_ID     = r_active_id;
  assign IR_CLR_SELECT = r_active_id;
  assign VECTOR        = c_VECTOR_BASE + {8'd0, r_active_id, 4'd0};
  assign INT_COUNT     = r_count;
  assign MASK          = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_arbiter
// Purpose  : Self-checking bench for interrupt_arbiter. Per-cycle vectors
//            carry inputs and the expected post-edge outputs; expectations
//            are queued when inputs are driven and popped after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_arbiter;

  logic        CLK;
  logic        RESET;
  logic [15:0] Interrupt_Register;
  logic        MASK_WRITE;
  logic [15:0] MASK_DATA;
  logic        INT_ACK;
  logic        RETI;
  logic        IRQ;
  logic [15:0] VECTOR;
  logic [3:0]  IR_CLR_SELECT;
  logic        IR_CLR;
  logic        IN_SERVICE;
  logic [3:0]  ACTIVE_ID;
  logic [7:0]  INT_COUNT;
  logic [15:0] MASK;
  logic [1:0]  arb_state;

  interrupt_arbiter dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .Interrupt_Register (Interrupt_Register),
    .MASK_WRITE         (MASK_WRITE),
    .MASK_DATA          (MASK_DATA),
    .INT_ACK            (INT_ACK),
    .RETI               (RETI),
    .IRQ                (IRQ),
    .VECTOR             (VECTOR),
    .IR_CLR_SELECT      (IR_CLR_SELECT),
    .IR_CLR             (IR_CLR),
    .IN_SERVICE         (IN_SERVICE),
    .ACTIVE_ID          (ACTIVE_ID),
    .INT_COUNT          (INT_COUNT),
    .MASK               (MASK),
    .arb_state          (arb_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        mw;
    logic [15:0] md;
    logic [15:0] ir;
    logic        ack;
    logic        reti;
    logic [1:0]  e_state;
    logic [3:0]  e_id;
    logic [15:0] e_vec;
    logic [7:0]  e_cnt;
    logic [15:0] e_mask;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[21];

  int n_checks = 0;
  int n_pass   = 0;
  logic clr_in_reset = 1'b0;

  // Any IR_CLR seen while reset is asserted is a violation.
  always @(posedge CLK or posedge RESET) begin
    if (RESET && IR_CLR) clr_in_reset = 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
  endtask

  function automatic vec_t mk(input logic mw, input logic [15:0] md,
                              input logic [15:0] ir, input logic ack,
                              input logic reti, input logic [1:0] st,
                              input logic [3:0] id, input logic [7:0] cnt,
                              input logic [15:0] msk);
    vec_t v;
    v.mw = mw; v.md = md; v.ir = ir; v.ack = ack; v.reti = reti;
    v.e_state = st; v.e_id = id; v.e_cnt = cnt; v.e_mask = msk;
    v.e_vec = 16'h0F00 + 16'(id) * 16'd16;
    return v;
  endfunction

  task automatic check_outputs(input vec_t e);
    chk("state",      int'(arb_state),     int'(e.e_state));
    chk("irq",        int'(IRQ),           int'(e.e_state == 2'd1));
    chk("ir_clr",     int'(IR_CLR),        int'(e.e_state == 2'd2));
    chk("in_service", int'(IN_SERVICE),    int'(e.e_state == 2'd3));
    chk("active_id",  int'(ACTIVE_ID),     int'(e.e_id));
    chk("clr_select", int'(IR_CLR_SELECT), int'(e.e_id));
    chk("vector",     int'(VECTOR),        int'(e.e_vec));
    chk("int_count",  int'(INT_COUNT),     int'(e.e_cnt));
    chk("mask",       int'(MASK),          int'(e.e_mask));
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge CLK);
    MASK_WRITE = v.mw; MASK_DATA = v.md; Interrupt_Register = v.ir;
    INT_ACK = v.ack; RETI = v.reti;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_outputs(e);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_state"},  int'(arb_state),     0);
    chk({tag, "_irq"},    int'(IRQ),           0);
    chk({tag, "_clr"},    int'(IR_CLR),        0);
    chk({tag, "_svc"},    int'(IN_SERVICE),    0);
    chk({tag, "_mask"},   int'(MASK),          0);
    chk({tag, "_id"},     int'(ACTIVE_ID),     0);
    chk({tag, "_sel"},    int'(IR_CLR_SELECT), 0);
    chk({tag, "_count"},  int'(INT_COUNT),     0);
    chk({tag, "_vector"}, int'(VECTOR),        16'h0F00);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] cnt;
    logic [3:0] id;

    RESET = 1'b1; MASK_WRITE = 1'b0; MASK_DATA = 16'h0;
    Interrupt_Register = 16'h0; INT_ACK = 1'b0; RETI = 1'b0;

    //           mw   md        ir        ack  reti st  id  cnt  mask
    tbl[0]  = mk(1, 16'hFFFF, 16'h0028, 0, 0, 0, 0,  0, 16'hFFFF); // old mask 0
    tbl[1]  = mk(0, 16'h0000, 16'h0028, 0, 0, 1, 3,  0, 16'hFFFF);
    tbl[2]  = mk(0, 16'h0000, 16'h0001, 0, 0, 1, 3,  0, 16'hFFFF); // no re-arb
    tbl[3]  = mk(0, 16'h0000, 16'h0000, 0, 0, 1, 3,  0, 16'hFFFF); // bit drops
    tbl[4]  = mk(0, 16'h0000, 16'h0000, 1, 0, 2, 3,  1, 16'hFFFF);
    tbl[5]  = mk(0, 16'h0000, 16'h0001, 0, 1, 3, 3,  1, 16'hFFFF); // RETI ignored
    tbl[6]  = mk(0, 16'h0000, 16'h0001, 1, 0, 3, 3,  1, 16'hFFFF); // ACK ignored
    tbl[7]  = mk(0, 16'h0000, 16'h0001, 0, 1, 0, 3,  1, 16'hFFFF);
    tbl[8]  = mk(0, 16'h0000, 16'h0001, 0, 0, 1, 0,  1, 16'hFFFF);
    tbl[9]  = mk(0, 16'h0000, 16'h0001, 1, 0, 2, 0,  2, 16'hFFFF);
    tbl[10] = mk(0, 16'h0000, 16'h0001, 0, 0, 3, 0,  2, 16'hFFFF);
    tbl[11] = mk(0, 16'h0000, 16'h0000, 0, 1, 0, 0,  2, 16'hFFFF);
    tbl[12] = mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0,  2, 16'h0000);
    tbl[13] = mk(0, 16'h0000, 16'hFFFF, 0, 0, 0, 0,  2, 16'h0000);
    tbl[14] = mk(0, 16'h0000, 16'hFFFF, 0, 0, 0, 0,  2, 16'h0000);
    tbl[15] = mk(1, 16'h8000, 16'hFFFF, 0, 0, 0, 0,  2, 16'h8000);
    tbl[16] = mk(0, 16'h0000, 16'hFFFF, 0, 0, 1, 15, 2, 16'h8000);
    tbl[17] = mk(1, 16'h0001, 16'hFFFF, 0, 0, 1, 15, 2, 16'h0001); // mask chg in REQ
    tbl[18] = mk(0, 16'h0000, 16'hFFFF, 1, 0, 2, 15, 3, 16'h0001);
    tbl[19] = mk(0, 16'h0000, 16'hFFFF, 0, 0, 3, 15, 3, 16'h0001);
    tbl[20] = mk(1, 16'hFFFF, 16'h0000, 0, 0, 3, 15, 3, 16'hFFFF); // mask wr in SERVICE

    #12;
    check_reset_state("reset");
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 21; i++) step(tbl[i]);

    // Saturation: repeated grant/ack/RETI rounds from SERVICE.
    cnt = 8'd3;
    id  = 4'd15;
    for (int i = 0; i < 260; i++) begin
      step(mk(0, 16'h0, 16'h0001, 0, 1, 0, id, cnt, 16'hFFFF));
      id = 4'd0;
      step(mk(0, 16'h0, 16'h0001, 0, 0, 1, id, cnt, 16'hFFFF));
      cnt = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
      step(mk(0, 16'h0, 16'h0001, 1, 0, 2, id, cnt, 16'hFFFF));
      step(mk(0, 16'h0, 16'h0001, 0, 0, 3, id, cnt, 16'hFFFF));
    end
    chk("count_saturated", int'(INT_COUNT), 255);

    // Reset asserted mid-REQ, between clock edges.
    step(mk(0, 16'h0, 16'h0001, 0, 1, 0, 0, 8'hFF, 16'hFFFF));
    step(mk(0, 16'h0, 16'h0001, 0, 0, 1, 0, 8'hFF, 16'hFFFF));
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1 check_reset_state("rst_req");
    @(posedge CLK);
    #1 check_reset_state("rst_req_hold");
    @(negedge CLK);
    RESET = 1'b0;

    // Resume: first edge after release loads the mask, next grants source 2.
    step(mk(1, 16'hFFFF, 16'h0004, 0, 0, 0, 0, 0, 16'hFFFF));
    step(mk(0, 16'h0000, 16'h0004, 0, 0, 1, 2, 0, 16'hFFFF));
    step(mk(0, 16'h0000, 16'h0004, 1, 0, 2, 2, 1, 16'hFFFF));
    step(mk(0, 16'h0000, 16'h0004, 0, 0, 3, 2, 1, 16'hFFFF));

    // Reset asserted mid-SERVICE.
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1 check_reset_state("rst_svc");
    @(posedge CLK);
    #1 check_reset_state("rst_svc_hold");
    chk("no_clr_in_reset", int'(clr_in_reset), 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1 chk("post_reset_idle", int'(arb_state), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
